immediate_generator: RTL and testbench
======================================

Name: immediate_generator

Overview:
RV32I immediate generator for the core's decode stage. It extracts and sign-extends (or zero-extends) the immediate field of a 32-bit instruction word according to its opcode format: I, S, B, U or J. The primary output is purely combinational. A registered copy is provided for pipelined consumers.

Parameters:
XLEN, 32, data width of the instruction and immediate; only 32 is supported.

Ports:
clk  input  1  system clock; clocks only the registered copy imm_q_o
rst  input  1  synchronous, active-high reset; affects only imm_q_o
instr_i  input  32  instruction word; opcode = instr_i[6:0], funct3 = instr_i[14:12]
imm_o  output  32  combinational immediate decoded from instr_i
imm_q_o  output  32  imm_o registered on the rising edge of clk

Behaviour:
- imm_o is combinational with zero latency.
  - It must be valid within the same delta/propagation as a change on instr_i.
  - clk and rst have no effect on imm_o.
- Decode by opcode (sext = sign-extend from the top bit of the extracted field):
  - OP-IMM 0010011, funct3 001 (SLLI) or 101 (SRLI/SRAI): imm = zero-extended instr[24:20] (shamt only). The funct7 bits are excluded.
  - OP-IMM 0010011, other funct3: imm = sext(instr[31:20]).
  - LOAD 0000011 and JALR 1100111: imm = sext(instr[31:20]).
  - STORE 0100011: imm = sext({instr[31:25], instr[11:7]}).
  - BRANCH 1100011: imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}). Bit 0 is always 0.
  - LUI 0110111 and AUIPC 0010111: imm = {instr[31:12], 12'b0}.
  - JAL 1101111: imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}). Bit 0 is always 0.
  - All other opcodes (R-type 0110011, SYSTEM, FENCE, illegal or unknown): imm = 32'h0000_0000.
- imm_o must never be X or Z for any fully known instr_i.
- imm_q_o:
  - On the rising edge of clk with rst=1: imm_q_o <= 0.
  - Otherwise: imm_q_o <= imm_o, giving one cycle of latency.
  - Reset value is 0. Reset is synchronous only; asserting rst between edges does not change imm_q_o until the next edge.
- No handshake, no internal state other than imm_q_o.

Test Plan:
- I-type signed: instr 0xFFF00093 (addi x1,x0,-1) -> imm_o 0xFFFFFFFF. Also instr 0x0080A103 (lw) -> imm_o 0x00000008.
- S-type: instr 0xFE20AE23 (sw x2,-4(x1)) -> imm_o 0xFFFFFFFC.
- B-type: instr 0xFE000CE3 (beq x0,x0,-8) -> imm_o 0xFFFFFFF8.
- U- and J-type:
  - instr 0x123452B7 (lui) -> imm_o 0x12345000.
  - instr 0x001000EF (jal x1,+2048) -> imm_o 0x00000800.
- Shift and default:
  - instr 0x4030D093 (srai x1,x1,3) -> imm_o 0x00000003.
  - instr 0x002081B3 (add) -> imm_o 0x00000000.
- Register path:
  - Hold rst=1 for one edge -> imm_q_o 0.
  - Release rst, apply 0x123452B7 -> imm_q_o 0x12345000 after the next rising edge; imm_o is correct immediately.

Source files
------------

// File: rtl/immediate_generator.sv
// RV32I immediate generator: decodes the I/S/B/U/J immediate of an instruction word
// combinationally, plus a one-cycle registered copy for pipelined consumers.
module immediate_generator #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] instr_i,
  output logic [XLEN-1:0] imm_o,
  output logic [XLEN-1:0] imm_q_o
);

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;

  logic [6:0] opcode;
  logic [2:0] funct3;

  logic signed [XLEN-1:0] imm_i_type;
  logic signed [XLEN-1:0] imm_s_type;
  logic signed [XLEN-1:0] imm_b_type;
  logic signed [XLEN-1:0] imm_u_type;
  logic signed [XLEN-1:0] imm_j_type;
  logic        [XLEN-1:0] imm_shamt;

  logic [XLEN-1:0] imm_d;
  logic [XLEN-1:0] imm_q;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];

  // Every format keeps its sign in instr[31], so replicating it sign-extends the field.
  assign imm_i_type = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s_type = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b_type = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                       instr_i[11:8], 1'b0};
  assign imm_u_type = {instr_i[31:12], 12'b0};
  assign imm_j_type = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                       instr_i[30:21], 1'b0};
  assign imm_shamt  = {27'b0, instr_i[24:20]};

  always_comb begin
    imm_o = '0;
    unique case (opcode)
      OP_IMM: begin
        // Shift-immediates carry funct7 in [31:25]; only the shift amount is an operand.
        if (funct3 == 3'b001 || funct3 == 3'b101) imm_o = imm_shamt;
        else                                       imm_o = imm_i_type;
      end
      LOAD, JALR:  imm_o = imm_i_type;
      STORE:       imm_o = imm_s_type;
      BRANCH:      imm_o = imm_b_type;
      LUI, AUIPC:  imm_o = imm_u_type;
      JAL:         imm_o = imm_j_type;
      default:     imm_o = '0;
    endcase
  end

  always_comb begin
    imm_d = rst ? '0 : imm_o;
  end

  // Registered stage boundary.
  always_ff @(posedge clk) begin
    imm_q <= imm_d;
  end

  assign imm_q_o = imm_q;

endmodule

// File: tb/tb_immediate_generator.sv
// Directed bench for immediate_generator: scoreboard queues hold hand-decoded
// immediates for the combinational and registered outputs.
module tb_immediate_generator;

  logic        clk;
  logic        rst;
  logic [31:0] instr_i;
  logic [31:0] imm_o;
  logic [31:0] imm_q_o;

  int tests_run;
  int tests_failed;

  logic [31:0] comb_q[$];
  logic [31:0] reg_q[$];

  immediate_generator #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .instr_i(instr_i),
    .imm_o  (imm_o),
    .imm_q_o(imm_q_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Drive one instruction between edges, check imm_o at once and imm_q_o after the edge.
  task automatic step(input string tag, input logic [31:0] instr, input logic [31:0] exp_imm);
    logic [31:0] e;
    @(negedge clk);
    instr_i = instr;
    comb_q.push_back(exp_imm);
    reg_q.push_back(rst ? 32'h0 : exp_imm);
    #1;
    e = comb_q.pop_front();
    check({tag, "_comb"}, imm_o, e);
    @(posedge clk);
    #1;
    e = reg_q.pop_front();
    check({tag, "_reg"}, imm_q_o, e);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    instr_i      = 32'h0;

    // Reset: one edge with rst high, even with a non-zero immediate on the input.
    step("reset", 32'hFFF00093, 32'hFFFFFFFF);
    rst = 1'b0;

    step("addi_m1",    32'hFFF00093, 32'hFFFFFFFF);
    step("lw_8",       32'h0080A103, 32'h00000008);
    step("sw_m4",      32'hFE20AE23, 32'hFFFFFFFC);
    step("beq_m8",     32'hFE000CE3, 32'hFFFFFFF8);
    step("beq_p4094",  32'h7E000FE3, 32'h00000FFE);
    step("lui",        32'h123452B7, 32'h12345000);
    step("auipc_top",  32'hFFFFF017, 32'hFFFFF000);
    step("jal_p2048",  32'h001000EF, 32'h00000800);
    step("jal_m2",     32'hFFFFF06F, 32'hFFFFFFFE);
    step("jalr_m4",    32'hFFC08067, 32'hFFFFFFFC);
    step("srai_3",     32'h4030D093, 32'h00000003);
    step("srai_31",    32'h41F0D093, 32'h0000001F);
    step("slli_31",    32'h01F09093, 32'h0000001F);
    step("add",        32'h002081B3, 32'h00000000);
    step("ecall",      32'h00000073, 32'h00000000);
    step("fence",      32'h0000000F, 32'h00000000);
    step("unknown",    32'hFFFFFFFF, 32'h00000000);
    step("lui_again",  32'h123452B7, 32'h12345000);

    // Reset raised mid-cycle must not disturb either output until the next edge.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_async_hold_reg", imm_q_o, 32'h12345000);
    check("rst_no_effect_comb", imm_o,   32'h12345000);
    @(posedge clk);
    #1;
    check("rst_sync_clear", imm_q_o, 32'h00000000);
    check("rst_comb_kept",  imm_o,   32'h12345000);
    rst = 1'b0;
    step("post_reset_sw", 32'hFE20AE23, 32'hFFFFFFFC);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
